// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for four requesters sharing one 2-to-4 decoded resource.
// Registered select/one-hot grant, hold timeout, and a mandatory idle cycle between owners.
module rr_decode_arbiter #(
   parameter int unsigned MAX_HOLD = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       done,
   output logic       grant_valid,
   output logic       sel1,
   output logic       sel0,
   output logic [3:0] grant_oh,
   output logic       timeout
);

   typedef enum logic {StIdle, StGrant} state_t;

   state_t     state_q, state_d;
   logic [1:0] ptr_q, ptr_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] sel_q, sel_d;
   logic [3:0] oh_q, oh_d;
   logic       gv_q, gv_d;
   logic       to_q, to_d;

   logic       pick_found;
   logic [1:0] pick_idx;
   logic [1:0] cand;

   // Search ptr+1, ptr+2, ptr+3, ptr; the last granted index gets lowest priority.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = 2'd0;
      cand       = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         cand = ptr_q + 2'(k);
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      oh_d    = oh_q;
      gv_d    = gv_q;
      to_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               sel_d   = pick_idx;
               oh_d    = 4'b0001 << pick_idx;
               gv_d    = 1'b1;
               cnt_d   = 8'd0;
               state_d = StGrant;
            end
         end
         StGrant: begin
            if (done || !req[sel_q] || (cnt_q == 8'(MAX_HOLD - 1))) begin
               // done has priority, so a simultaneous timeout condition is a normal release
               to_d    = !done && req[sel_q];
               gv_d    = 1'b0;
               oh_d    = 4'b0000;
               ptr_d   = sel_q;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         ptr_q   <= 2'd3;
         cnt_q   <= 8'd0;
         sel_q   <= 2'd0;
         oh_q    <= 4'b0000;
         gv_q    <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         oh_q    <= oh_d;
         gv_q    <= gv_d;
         to_q    <= to_d;
      end
   end

   assign grant_valid = gv_q;
   assign sel1        = sel_q[1];
   assign sel0        = sel_q[0];
   assign grant_oh    = oh_q;
   assign timeout     = to_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed table-driven bench for rr_decode_arbiter with MAX_HOLD=4.
module tb_rr_decode_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       done;
   logic       grant_valid, sel1, sel0, timeout;
   logic [3:0] grant_oh;

   int checks   = 0;
   int failures = 0;

   rr_decode_arbiter #(.MAX_HOLD(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .done       (done),
      .grant_valid(grant_valid),
      .sel1       (sel1),
      .sel0       (sel0),
      .grant_oh   (grant_oh),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       done;
      logic       gv;
      logic [1:0] sel;
      logic [3:0] oh;
      logic       to;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [3:0] rq, input logic d, input logic gv,
                      input logic [1:0] sel, input logic [3:0] oh, input logic to);
      vec_t v;
      v.rst = r; v.req = rq; v.done = d; v.gv = gv; v.sel = sel; v.oh = oh; v.to = to;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic gv, input logic [1:0] sel,
                        input logic [3:0] oh, input logic to);
      logic [7:0] act, exp;
      act = {grant_valid, sel1, sel0, grant_oh, timeout};
      exp = {gv, sel, oh, to};
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got gv=%b sel=%b%b oh=%b to=%b, expected gv=%b sel=%b oh=%b to=%b",
                  name, grant_valid, sel1, sel0, grant_oh, timeout, gv, sel, oh, to);
      end
   endtask

   task automatic step(input logic r, input logic [3:0] rq, input logic d);
      rst = r; req = rq; done = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; req = 4'b0; done = 1'b0;

      // Single request to 2, done on the 3rd grant cycle
      add(0, 4'b0100, 0, 1, 2'd2, 4'b0100, 0);
      add(0, 4'b0100, 0, 1, 2'd2, 4'b0100, 0);
      add(0, 4'b0100, 0, 1, 2'd2, 4'b0100, 0);
      add(0, 4'b0100, 1, 0, 2'd2, 4'b0000, 0);
      add(0, 4'b0000, 0, 0, 2'd2, 4'b0000, 0);
      // Reset, then rotation 0,1,2,3,0 with all requesting
      add(1, 4'b0000, 0, 0, 2'd0, 4'b0000, 0);
      add(0, 4'b1111, 0, 1, 2'd0, 4'b0001, 0);
      add(0, 4'b1111, 1, 0, 2'd0, 4'b0000, 0);
      add(0, 4'b1111, 0, 1, 2'd1, 4'b0010, 0);
      add(0, 4'b1111, 1, 0, 2'd1, 4'b0000, 0);
      add(0, 4'b1111, 0, 1, 2'd2, 4'b0100, 0);
      add(0, 4'b1111, 1, 0, 2'd2, 4'b0000, 0);
      add(0, 4'b1111, 0, 1, 2'd3, 4'b1000, 0);
      add(0, 4'b1111, 1, 0, 2'd3, 4'b0000, 0);
      add(0, 4'b1111, 0, 1, 2'd0, 4'b0001, 0);
      add(0, 4'b1111, 1, 0, 2'd0, 4'b0000, 0);
      // Priority after pointer: grant 2, then 0101 -> 0, then 0101 -> 2
      add(0, 4'b0100, 0, 1, 2'd2, 4'b0100, 0);
      add(0, 4'b0100, 1, 0, 2'd2, 4'b0000, 0);
      add(0, 4'b0101, 0, 1, 2'd0, 4'b0001, 0);
      add(0, 4'b0101, 1, 0, 2'd0, 4'b0000, 0);
      add(0, 4'b0101, 0, 1, 2'd2, 4'b0100, 0);
      add(0, 4'b0101, 1, 0, 2'd2, 4'b0000, 0);
      // Timeout: exactly 4 grant cycles, pulse, then re-grant of 1
      add(0, 4'b0010, 0, 1, 2'd1, 4'b0010, 0);
      add(0, 4'b0010, 0, 1, 2'd1, 4'b0010, 0);
      add(0, 4'b0010, 0, 1, 2'd1, 4'b0010, 0);
      add(0, 4'b0010, 0, 1, 2'd1, 4'b0010, 0);
      add(0, 4'b0010, 0, 0, 2'd1, 4'b0000, 1);
      add(0, 4'b0010, 0, 1, 2'd1, 4'b0010, 0);
      // Variant: done on the 4th cycle suppresses timeout
      add(0, 4'b0010, 0, 1, 2'd1, 4'b0010, 0);
      add(0, 4'b0010, 0, 1, 2'd1, 4'b0010, 0);
      add(0, 4'b0010, 0, 1, 2'd1, 4'b0010, 0);
      add(0, 4'b0010, 1, 0, 2'd1, 4'b0000, 0);
      // Withdraw mid-grant
      add(0, 4'b0001, 0, 1, 2'd0, 4'b0001, 0);
      add(0, 4'b0001, 0, 1, 2'd0, 4'b0001, 0);
      add(0, 4'b0000, 0, 0, 2'd0, 4'b0000, 0);
      // Reset during grant restores ptr=3, so 1001 grants 0
      add(0, 4'b0100, 0, 1, 2'd2, 4'b0100, 0);
      add(1, 4'b0100, 0, 0, 2'd0, 4'b0000, 0);
      add(0, 4'b1001, 0, 1, 2'd0, 4'b0001, 0);
      add(0, 4'b1001, 1, 0, 2'd0, 4'b0000, 0);

      // Reset for two cycles, then ten idle cycles with no requests
      step(1, 4'b0000, 0);
      step(1, 4'b0000, 0);
      check("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(0, 4'b0000, 0);
         check($sformatf("idle%0d", i), 1'b0, 2'd0, 4'b0000, 1'b0);
      end

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].req, vecs[i].done);
         check($sformatf("vec%0d", i), vecs[i].gv, vecs[i].sel, vecs[i].oh, vecs[i].to);
      end

      // Held request with no done: the grant must time out within the bound
      begin
         int gv_cycles;
         gv_cycles = 0;
         step(0, 4'b1000, 0);
         for (int i = 0; i < 10 && grant_valid; i++) begin
            gv_cycles++;
            step(0, 4'b1000, 0);
         end
         checks++;
         if (gv_cycles != 4 || timeout !== 1'b1) begin
            failures++;
            $display("FAIL hold_len: got %0d cycles timeout=%b, expected 4 cycles timeout=1",
                     gv_cycles, timeout);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_decode_arbiter.md
# rr_decode_arbiter

Round-robin arbiter sharing one 2-to-4 decoder-driven resource among four requesters. Selects one requester at a time, drives the 2-bit select (`sel1`, `sel0`) feeding the decoder plus a registered one-hot grant, holds the grant until release or timeout, and rotates priority so no requester starves. Sits between the four requesting units and the shared decoder/resource in the lab datapath.

## Interface
Parameters:
- `MAX_HOLD`, 15, maximum grant length in cycles; legal range 2..255.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `req`  input  4  request lines; bit i = requester i.
- `done`  input  1  owner finished; sampled only while `grant_valid`=1.
- `grant_valid`  output  1  a grant is active.
- `sel1`  output  1  MSB of granted index; drives decoder `in1`.
- `sel0`  output  1  LSB of granted index; drives decoder `in0`.
- `grant_oh`  output  4  one-hot grant; equals decoded {`sel1`,`sel0`} when `grant_valid`=1, else 0.
- `timeout`  output  1  one-cycle pulse when a grant is force-released.

## Operation
- States: IDLE, GRANT. All outputs registered.
- Reset: state=IDLE, last-granted pointer `ptr`=3, hold counter=0; `grant_valid`=0, `sel1`=0, `sel0`=0, `grant_oh`=4'b0000, `timeout`=0.
- IDLE: if `req`≠0, pick first set bit searching `ptr`+1, `ptr`+2, `ptr`+3, `ptr` (mod 4). Load index into {`sel1`,`sel0`}, set `grant_oh`, `grant_valid`=1, counter=0, go GRANT. If `req`=0, stay IDLE; `sel1`/`sel0` hold last values.
- GRANT, per cycle, release conditions in priority order:
  1. `done`=1 → normal release.
  2. `req[idx]`=0 → normal release (requester withdrew).
  3. counter = `MAX_HOLD`-1 → forced release, `timeout`=1 next cycle.
  4. otherwise counter += 1, stay GRANT.
- On any release: next cycle `grant_valid`=0, `grant_oh`=0, state=IDLE, `ptr`=granted index. `sel1`/`sel0` keep the released index.
- `done` simultaneous with timeout condition: normal release, no `timeout` pulse.
- Counter 8 bits, never wraps; it is cleared on each new grant.
- `done` and `req` changes in IDLE do not affect `ptr`.
- `rst` asserted mid-grant: next edge applies full reset values regardless of state; `ptr` returns to 3, so requester 0 has top priority after reset.

## Timing
- Request to grant: `req` sampled in IDLE at edge N → `grant_valid`=1 after edge N (visible cycle N+1).
- Release: `done` high at edge M → `grant_valid`=0 after edge M. The IDLE cycle is mandatory, so the next grant is visible no earlier than M+2. This gives a guaranteed 1-cycle dead gap between owners.
- Max grant length is exactly `MAX_HOLD` cycles with `grant_valid`=1. `timeout` is high during the first cycle with `grant_valid`=0 after a forced release.
- `grant_oh` and {`sel1`,`sel0`} change on the same edge; there is never more than one `grant_oh` bit set.

## Test plan
- Reset and idle: `rst`=1 for 2 cycles, `req`=0 → all outputs 0, `grant_valid` stays 0 for 10 cycles.
- Single request: `req`=4'b0100, `done` pulsed on 3rd grant cycle → `sel1`=1, `sel0`=0, `grant_oh`=4'b0100 one cycle after `req`. Grant lasts 3 cycles, then 1 cycle of `grant_valid`=0.
- Round-robin rotation: `req`=4'b1111 held, `done` pulsed every grant → grant order 0,1,2,3,0, each separated by one idle cycle.
- Priority after pointer: after granting 2, `req`=4'b0101 → next grant is 0. Then `req`=4'b0101 again → 2.
- Timeout with `MAX_HOLD`=4: `req`=4'b0010 held, `done`=0 → `grant_valid` high exactly 4 cycles, then `timeout`=1 for 1 cycle, then re-grant of 1 when it is the only requester. Variant: `done`=1 on the 4th cycle → no `timeout`.
- Withdraw and mid-grant reset: requester drops `req` mid-grant → release next cycle, no `timeout`. `rst` asserted during GRANT → outputs 0 next cycle, then `req`=4'b1001 grants 0 first.
